descrambler_done: RTL
=====================

DESCRAMBLER_DONE -- requirements
Module: descrambler_done

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request to descramble; sampled only in IDLE.
- mode  in  2  00 inverse, 01 bypass-check, 10 inverse-reversed, 11 reserved.
- index1..index6  in  3 each  scrambled sequence; expected to be a permutation of 0..5.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on rejected input.
- orig1..orig6  out  3 each  descrambled sequence; held between requests.

Function
REQ-002 The block SHALL implement states IDLE, SCAN, DONE and ERR.
REQ-003 In IDLE with start=1, the block SHALL capture index1..index6 and mode into internal registers, clear the seen-bitmap (6 bits) and the element counter, and go to SCAN.
REQ-004 In IDLE with start=1 and mode=11, the block SHALL go directly to ERR without scanning.
REQ-005 Input changes after the capture edge SHALL NOT affect the result.
REQ-006 SCAN SHALL examine exactly one captured element per cycle, in order 1 to 6, using a 3-bit counter 0..5.
REQ-007 For element at position p with value v: if v>5 or seen[v]=1, the block SHALL go to ERR; otherwise it SHALL set seen[v] and write inv[v]=p.
REQ-008 After the element at p=5 passes, the block SHALL go to DONE.
REQ-009 A valid request SHALL produce done high in the 7th cycle after the capture edge.
REQ-010 An invalid element SHALL produce err high in the cycle after the edge that examined it.
REQ-011 On entry to DONE, the outputs SHALL be loaded as follows:
- mode 00: orig(k+1)=inv[k].
- mode 01: orig(k+1)=captured index(k+1).
- mode 10: orig(k+1)=inv[5-k].
REQ-012 DONE and ERR SHALL each last exactly one cycle and then return to IDLE.
REQ-013 On an error, orig1..orig6 SHALL keep their previous values.
REQ-014 busy SHALL be high in SCAN, DONE and ERR, and low in IDLE.
REQ-015 start SHALL be ignored while busy=1; no request is queued.
REQ-016 done and err SHALL never be high in the same cycle.
REQ-017 start held high SHALL begin a new request on the first IDLE cycle after DONE or ERR.
REQ-018 The inverse table and the counter SHALL stay within 0..5; the counter SHALL NOT wrap inside SCAN.

Reset
REQ-019 While rst=0, the block SHALL immediately force state IDLE, and busy, done and err to 0.
REQ-020 While rst=0, orig1..orig6, inv, the seen-bitmap, the counter and the captured registers SHALL all be forced to 0.
REQ-021 Reset asserted mid-SCAN SHALL abandon the request with no done or err pulse.
REQ-022 Reset deassertion SHALL take effect on the next rising clk edge; start sampled on that edge SHALL be honoured.

Structure
REQ-023 A shared package SHALL hold:
- the state encoding;
- mode constants MODE_INV, MODE_BYP, MODE_REV, MODE_RSV;
- the constant N_IDX=6 and the index width 3.
REQ-024 One sub-module SHALL exist: perm_check_step.
- Combinational.
- Inputs: value and seen-bitmap.
- Outputs: valid flag and updated bitmap.
REQ-025 The top level SHALL contain the FSM, counter, capture registers, inverse table and output registers.

Verification
REQ-026 Mode 00 with inputs (3,0,5,1,2,4):
- done 7 cycles after capture;
- orig=(1,3,4,0,5,2);
- busy high 7 cycles;
- err never high.
REQ-027 Mode 10 with the same inputs -> orig=(2,5,0,4,3,1). Mode 01 with the same inputs -> orig=(3,0,5,1,2,4).
REQ-028 Duplicate input (0,1,2,2,4,5), mode 00:
- err in the 5th cycle after capture;
- done never high;
- orig unchanged from the prior result.
REQ-029 Out-of-range input (6,...) -> err in the 2nd cycle after capture. Mode 11 -> err in the 1st cycle after capture.
REQ-030 Inputs and start toggled mid-SCAN -> result matches the captured inputs and no second request starts.
REQ-031 rst pulsed low at the 3rd SCAN cycle:
- all outputs 0 immediately;
- no done or err pulse;
- start after release -> normal 7-cycle completion.

Source files
------------

// File: rtl/descrambler_done_pkg.sv
// Shared types and constants for the permutation descrambler.
package descrambler_done_pkg;

    localparam int N_IDX = 6;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INV = 2'b00;
    localparam logic [1:0] MODE_BYP = 2'b01;
    localparam logic [1:0] MODE_REV = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

endpackage

// File: rtl/descrambler_done_perm_check_step.sv
// One step of permutation checking: accepts a value if it is in range and unseen.
module perm_check_step
    import descrambler_done_pkg::*;
(
    input  logic [IDX_W-1:0] value,
    input  logic [N_IDX-1:0] seen,
    output logic             valid,
    output logic [N_IDX-1:0] seen_next
);

    // Out-of-range values match no slot and therefore stay invalid.
    always_comb begin
        valid     = 1'b0;
        seen_next = seen;
        for (int k = 0; k < N_IDX; k++) begin
            if (value == IDX_W'(k) && !seen[k]) begin
                valid        = 1'b1;
                seen_next[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/descrambler_done.sv
// Validates a captured 6-element permutation one element per cycle and emits its inverse.
module descrambler_done
    import descrambler_done_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [IDX_W-1:0] index1,
    input  logic [IDX_W-1:0] index2,
    input  logic [IDX_W-1:0] index3,
    input  logic [IDX_W-1:0] index4,
    input  logic [IDX_W-1:0] index5,
    input  logic [IDX_W-1:0] index6,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] orig1,
    output logic [IDX_W-1:0] orig2,
    output logic [IDX_W-1:0] orig3,
    output logic [IDX_W-1:0] orig4,
    output logic [IDX_W-1:0] orig5,
    output logic [IDX_W-1:0] orig6
);

    state_t           state;
    logic [1:0]       cap_mode;
    logic [IDX_W-1:0] cap_idx   [N_IDX];
    logic [IDX_W-1:0] inv       [N_IDX];
    logic [IDX_W-1:0] orig_r    [N_IDX];
    logic [N_IDX-1:0] seen;
    logic [IDX_W-1:0] cnt;

    logic [IDX_W-1:0] cur_val;
    logic             step_ok;
    logic [N_IDX-1:0] seen_next;
    logic [IDX_W-1:0] inv_next  [N_IDX];
    logic [IDX_W-1:0] orig_next [N_IDX];

    assign cur_val = cap_idx[cnt];

    perm_check_step u_step (
        .value     (cur_val),
        .seen      (seen),
        .valid     (step_ok),
        .seen_next (seen_next)
    );

    // The last element's inverse entry is written on the same edge that loads
    // the outputs, so the output mapping works from the updated table.
    always_comb begin
        for (int k = 0; k < N_IDX; k++) begin
            inv_next[k] = inv[k];
            if (step_ok && cur_val == IDX_W'(k))
                inv_next[k] = cnt;
        end
        for (int k = 0; k < N_IDX; k++) begin
            case (cap_mode)
                MODE_BYP: orig_next[k] = cap_idx[k];
                MODE_REV: orig_next[k] = inv_next[N_IDX-1-k];
                default:  orig_next[k] = inv_next[k];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cap_mode <= '0;
            seen     <= '0;
            cnt      <= '0;
            for (int k = 0; k < N_IDX; k++) begin
                cap_idx[k] <= '0;
                inv[k]     <= '0;
                orig_r[k]  <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_idx[0] <= index1;
                        cap_idx[1] <= index2;
                        cap_idx[2] <= index3;
                        cap_idx[3] <= index4;
                        cap_idx[4] <= index5;
                        cap_idx[5] <= index6;
                        cap_mode   <= mode;
                        seen       <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        if (mode == MODE_RSV) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (!step_ok) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        seen <= seen_next;
                        for (int k = 0; k < N_IDX; k++)
                            inv[k] <= inv_next[k];
                        if (cnt == IDX_W'(N_IDX - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            for (int k = 0; k < N_IDX; k++)
                                orig_r[k] <= orig_next[k];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign orig1 = orig_r[0];
    assign orig2 = orig_r[1];
    assign orig3 = orig_r[2];
    assign orig4 = orig_r[3];
    assign orig5 = orig_r[4];
    assign orig6 = orig_r[5];

endmodule
